// File: rtl/dmem_result_capture_if.sv
// Purpose : bundles the snooped tp1 core buses and the result stream port.
// Latency : n/a (signal bundle only).
// Backpressure: the result stream is valid/ready; the snooped buses are never stalled.
// Signals:
//   _iInstMemAddr, _iDataMemAddr, _iDataMemWData, _iDataMemWrite : core buses (snooped)
//   _oResValid, _oResData, _iResReady : result FIFO head, valid/ready
//   _oFifoLevel, _oOverflow, _oDropCount : FIFO status
// Modports: master = core/consumer side, slave = result capture block.
interface dmem_result_capture_if #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]   _iInstMemAddr;
  logic [ADDR_W-1:0]   _iDataMemAddr;
  logic [DATA_W-1:0]   _iDataMemWData;
  logic                _iDataMemWrite;
  logic                _oResValid;
  logic [2*DATA_W-1:0] _oResData;
  logic                _iResReady;
  logic [LVL_W-1:0]    _oFifoLevel;
  logic                _oOverflow;
  logic [7:0]          _oDropCount;

  modport master (
    output _iInstMemAddr, _iDataMemAddr, _iDataMemWData, _iDataMemWrite, _iResReady,
    input  _oResValid, _oResData, _oFifoLevel, _oOverflow, _oDropCount
  );

  modport slave (
    input  _iInstMemAddr, _iDataMemAddr, _iDataMemWData, _iDataMemWrite, _iResReady,
    output _oResValid, _oResData, _oFifoLevel, _oOverflow, _oDropCount
  );
endinterface

// File: rtl/dmem_result_capture.sv
// Purpose : snoops tp1 result-byte writes and pushes {hi,lo} into a FIFO once per DONE_PC visit.
// Latency : push at a DONE edge is visible on _oResValid/_oResData the following cycle.
// Backpressure: consumer stalls via _iResReady; a push into a full FIFO is dropped and counted.
// Ports:
//   _iClk, _iReset : clock, synchronous active-high reset
//   bus (slave)    : snooped inst/data buses, result valid/ready head, level/overflow/drop count
module dmem_result_capture #(
  parameter int              DATA_W      = 8,
  parameter int              ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RES_LO_ADDR = 8'h02,
  parameter logic [ADDR_W-1:0] RES_HI_ADDR = 8'h03,
  parameter logic [ADDR_W-1:0] DONE_PC     = 8'h87,
  parameter int              FIFO_DEPTH  = 4
) (
  input  logic                 _iClk,
  input  logic                 _iReset,
  dmem_result_capture_if.slave bus
);

  localparam int RES_W = 2 * DATA_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [0:0] {
    S_WAIT_DONE = 1'b0,
    S_AT_DONE   = 1'b1
  } state_t;

  // State
  state_t             r_state;
  logic [DATA_W-1:0]  r_lo;
  logic [DATA_W-1:0]  r_hi;
  logic [RES_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_valid;
  logic [RES_W-1:0]   r_head;
  logic               r_ovf;
  logic [7:0]         r_drop;

  // Next-state helpers
  logic [DATA_W-1:0]  w_lo_nxt;
  logic [DATA_W-1:0]  w_hi_nxt;
  logic [RES_W-1:0]   w_push_dat;
  logic               w_at_done;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_accept;
  logic               w_drop;
  logic [PTR_W-1:0]   w_rptr_nxt;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [RES_W-1:0]   w_head_nxt;

  always_comb begin
    // Shadow update, forwarded so a result write in the trigger cycle is captured.
    w_lo_nxt = r_lo;
    w_hi_nxt = r_hi;
    if (bus._iDataMemWrite) begin
      if (bus._iDataMemAddr == RES_LO_ADDR) w_lo_nxt = bus._iDataMemWData;
      if (bus._iDataMemAddr == RES_HI_ADDR) w_hi_nxt = bus._iDataMemWData;
    end
    w_push_dat = {w_hi_nxt, w_lo_nxt};

    w_at_done = (bus._iInstMemAddr == DONE_PC);
    w_push    = (r_state == S_WAIT_DONE) && w_at_done;
    w_pop     = r_valid && bus._iResReady;
    w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_accept  = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;

    w_rptr_nxt = w_pop ? (r_rptr + PTR_W'(1)) : r_rptr;

    w_level_nxt = r_level;
    if (w_accept && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
    else if (!w_accept && w_pop) w_level_nxt = r_level - LVL_W'(1);

    // The registered head is precomputed so outputs stay flop-driven. When the
    // new head slot is the one being written this edge, take the push data.
    w_head_nxt = '0;
    if (w_level_nxt != '0) begin
      if (w_accept && (r_wptr == w_rptr_nxt)) w_head_nxt = w_push_dat;
      else                                    w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  // Storage array carries no reset; pointers/level define what is live.
  always_ff @(posedge _iClk) begin
    if (w_accept && !_iReset) r_mem[r_wptr] <= w_push_dat;
  end

  always_ff @(posedge _iClk) begin
    if (_iReset) begin
      r_state <= S_WAIT_DONE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_lo <= w_lo_nxt;
      r_hi <= w_hi_nxt;

      case (r_state)
        S_WAIT_DONE: if (w_at_done)  r_state <= S_AT_DONE;
        S_AT_DONE:   if (!w_at_done) r_state <= S_WAIT_DONE;
        default:                     r_state <= S_WAIT_DONE;
      endcase

      if (w_accept) r_wptr <= r_wptr + PTR_W'(1);
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
      r_head  <= w_head_nxt;

      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign bus._oResValid  = r_valid;
  assign bus._oResData   = r_head;
  assign bus._oFifoLevel = r_level;
  assign bus._oOverflow  = r_ovf;
  assign bus._oDropCount = r_drop;

endmodule
